// File: rtl/div_iter_pkg.sv
// Shared types for the iterative radix-2 divider.
// FSM encoding and counter sizing helper.
package div_iter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic int cnt_bits(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit,
// subtract the divisor when it fits.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < divisor, so the shifted value always fits WIDTH+1 bits
    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0]
                           : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for the EX stage.
// Signed/unsigned, cancel, divide-by-zero and early-out.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               cancel_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               div_zero_o
);

    localparam int CW = cnt_bits(WIDTH);

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [WIDTH-1:0]   a_q, a_n;
    logic [WIDTH-1:0]   b_q, b_n;
    logic [WIDTH-1:0]   rem_q, rem_n;
    logic [WIDTH-1:0]   quo_q, quo_n;
    logic               neg_q, neg_q_n;
    logic               neg_r, neg_r_n;
    logic [2*WIDTH-1:0] res_q, res_n;
    logic               dz_q, dz_n;

    logic               sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               is_zero, is_early;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    logic [WIDTH-1:0]   q_fix, r_fix;

    // negating INT_MIN yields 2^(WIDTH-1), read as unsigned below
    assign sa    = signed_i & dividend_i[WIDTH-1];
    assign sb    = signed_i & divisor_i[WIDTH-1];
    assign abs_a = sa ? -dividend_i : dividend_i;
    assign abs_b = sb ? -divisor_i : divisor_i;

    assign is_zero  = (divisor_i == '0);
    assign is_early = EARLY_OUT &&
                      ((abs_a == '0) || (abs_a < abs_b));

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .bit_in  (a_q[WIDTH-1]),
        .divisor (b_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign q_fix = neg_q ? -quo_q : quo_q;
    assign r_fix = neg_r ? -rem_q : rem_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = a_q;
        b_n     = b_q;
        rem_n   = rem_q;
        quo_n   = quo_q;
        neg_q_n = neg_q;
        neg_r_n = neg_r;
        res_n   = res_q;
        dz_n    = dz_q;
        if (cancel_i) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    state_n = S_IDLE;
                    if (start_i) begin
                        neg_q_n = sa ^ sb;
                        neg_r_n = sa;
                        if (is_zero) begin
                            dz_n    = 1'b1;
                            res_n   = {dividend_i,
                                       {WIDTH{1'b1}}};
                            state_n = S_DONE;
                        end else if (is_early) begin
                            dz_n    = 1'b0;
                            res_n   = {dividend_i,
                                       {WIDTH{1'b0}}};
                            state_n = S_DONE;
                        end else begin
                            dz_n    = 1'b0;
                            cnt_n   = CW'(WIDTH);
                            rem_n   = '0;
                            quo_n   = '0;
                            a_n     = abs_a;
                            b_n     = abs_b;
                            state_n = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_n = step_rem;
                    quo_n = {quo_q[WIDTH-2:0], step_q};
                    a_n   = {a_q[WIDTH-2:0], 1'b0};
                    cnt_n = cnt - 1'b1;
                    if (cnt == CW'(1))
                        state_n = S_FIX;
                end
                S_FIX: begin
                    res_n   = {r_fix, q_fix};
                    state_n = S_DONE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            rem_q <= '0;
            quo_q <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            res_q <= '0;
            dz_q  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            a_q   <= a_n;
            b_q   <= b_n;
            rem_q <= rem_n;
            quo_q <= quo_n;
            neg_q <= neg_q_n;
            neg_r <= neg_r_n;
            res_q <= res_n;
            dz_q  <= dz_n;
        end
    end

    assign busy_o     = (state == S_CALC) ||
                        (state == S_FIX);
    assign done_o     = (state == S_DONE) && !cancel_i;
    assign result_o   = res_q;
    assign div_zero_o = dz_q;

endmodule
